rdi_wake_handshake: RTL and testbench
=====================================

// Module: rdi_wake_handshake
// PURPOSE
// - RDI-side (UCIe Raw D2D Interface) wake/clock-gating controller, in the rdi_clk domain.
// - Owns the clock-gate enable for the LTSM/mainband logic.
// - Answers the adapter's lp_wake_req with pl_wake_ack once the LTSM confirms its clock runs.
// - i_ltsm_is_waked_up is o_clk_gate_en after a round trip through 2 two-flop synchronizers (~4-6 i_clk cycles).
// PARAMETERS
// - IDLE_CYCLES  16  consecutive idle cycles required in UNGATED before re-gating (>=1)
// - CNT_W        5   idle counter width; must hold IDLE_CYCLES
// PORTS
// - i_clk               in   1  RDI clock (SB PLL / 8)
// - i_rst               in   1  synchronous active-high reset
// - i_pl_state_sts      in   4  PL state: 0000 Reset, 0001 Active, 0011 PMNAK, 0100 L1, 1000 L2, 1001 LinkReset, 1010 LinkError, 1011 Retrain, 1100 Disabled
// - i_lp_state_req      in   4  adapter state request; 0000 = NOP
// - i_ltsm_in_reset     in   1  1 = LTSM in RESET state
// - i_lp_wake_req       in   1  adapter wake request (level)
// - i_ltsm_is_waked_up  in   1  synchronized confirmation that the gated clock is running
// - o_clk_gate_en       out  1  1 = ungate LTSM/mainband clock
// - o_pl_wake_ack       out  1  wake acknowledge to adapter (level)
// Interface: one clock; reset is synchronous and active-high.
// BEHAVIOUR
// - Reset:
//   - Applied on any posedge i_clk with i_rst=1, including mid-handshake.
//   - state=GATED, o_clk_gate_en=0, o_pl_wake_ack=0, idle counter=0.
// - All outputs are registered Moore outputs decoded from state.
//   - gate_en = 1 in WAKING, ACK and UNGATED.
//   - ack = 1 only in ACK.
// - wake_cond = i_lp_wake_req | ~i_ltsm_in_reset.
// - idle = ~i_lp_wake_req & (i_lp_state_req==0) & i_ltsm_in_reset & pl_state_sts in {Reset, L1, L2, Disabled}.
// - FSM:
//   - GATED:
//     - -> WAKING if wake_cond and i_ltsm_is_waked_up==0.
//     - If i_ltsm_is_waked_up is still 1 from a previous gating, stay in GATED until it drops.
//     - This prevents a stale confirmation from producing a false ack.
//   - WAKING:
//     - Wait for i_ltsm_is_waked_up==1.
//     - Then -> ACK if i_lp_wake_req==1, else -> UNGATED.
//   - ACK:
//     - Hold until i_lp_wake_req==0, then -> UNGATED; ack falls on the next edge.
//     - If i_ltsm_is_waked_up drops while in ACK, -> WAKING (ack drops, gate_en stays 1).
//   - UNGATED:
//     - If i_lp_wake_req==1 and i_ltsm_is_waked_up==1: -> ACK next cycle.
//     - If i_lp_wake_req==1 and i_ltsm_is_waked_up==0: -> WAKING.
//     - Else if idle: increment counter; when it reaches IDLE_CYCLES-1 -> GATED.
//     - Any non-idle cycle clears the counter.
// - Latency:
//   - wake_req sampled at edge N -> gate_en=1 after edge N.
//   - waked_up sampled 1 at edge M -> ack=1 after edge M.
// - Simultaneous events:
//   - If wake_req rises on the same edge the idle counter expires, wake wins and the state stays UNGATED.
//   - Ack never asserts without gate_en=1.
// - A deasserted wake_req while in WAKING produces no ack pulse.
// TESTING
// - Bench model: i_ltsm_is_waked_up = o_clk_gate_en delayed 4 cycles.
// - Scenario 1: reset 2 cycles, inputs 0, ltsm_in_reset=1 -> gate_en=0, ack=0, stays 0 for 50 cycles.
// - Scenario 2: wake_req=1 at cycle 3 -> gate_en=1 at cycle 4; ack=1 about 5 cycles later (after waked_up); ack stays 1 while wake_req=1.
// - Scenario 3: in ACK, drop wake_req and set state_req=0001 -> ack=0 next cycle; gate_en stays 1 while state_req!=0.
// - Scenario 4: all idle, pl_state_sts=0100 -> gate_en=0 exactly 16 cycles after idle starts; a wake_req at cycle 10 aborts gating.
// - Scenario 5: wake_req pulsed 2 cycles then dropped before waked_up -> gate_en=1 and no ack pulse; re-wake after gating waits for waked_up=0 before ack.
// - Scenario 6: i_rst=1 during ACK -> gate_en=0 and ack=0 after the next edge.

Source files
------------

// File: rtl/rdi_wake_handshake.sv
`default_nettype none
// ============================================================================
// Module      : rdi_wake_handshake
// Description : RDI wake/clock-gating controller: owns the LTSM clock-gate
//               enable and answers lp_wake_req once the gated clock is confirmed.
// Revision    : 1.0 - initial release
// ============================================================================
module rdi_wake_handshake #(
   parameter int IDLE_CYCLES = 16,
   parameter int CNT_W       = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_pl_state_sts,
   input  logic [3:0] i_lp_state_req,
   input  logic       i_ltsm_in_reset,
   input  logic       i_lp_wake_req,
   input  logic       i_ltsm_is_waked_up,
   output logic       o_clk_gate_en,
   output logic       o_pl_wake_ack
);

   typedef enum logic [1:0] {
      ST_GATED   = 2'd0,
      ST_WAKING  = 2'd1,
      ST_ACK     = 2'd2,
      ST_UNGATED = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_idle_last   = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [3:0]       c_pl_reset    = 4'b0000;
   localparam logic [3:0]       c_pl_l1       = 4'b0100;
   localparam logic [3:0]       c_pl_l2       = 4'b1000;
   localparam logic [3:0]       c_pl_disabled = 4'b1100;

   state_t           r_state;
   state_t           w_nxt_state;
   logic [CNT_W-1:0] r_idle_cnt;
   logic [CNT_W-1:0] w_nxt_cnt;
   logic             w_wake_cond;
   logic             w_pl_quiet;
   logic             w_idle;

   assign w_wake_cond = i_lp_wake_req | ~i_ltsm_in_reset;
   assign w_pl_quiet  = (i_pl_state_sts == c_pl_reset) | (i_pl_state_sts == c_pl_l1) |
                        (i_pl_state_sts == c_pl_l2)    | (i_pl_state_sts == c_pl_disabled);
   assign w_idle      = ~i_lp_wake_req & (i_lp_state_req == 4'b0000) &
                        i_ltsm_in_reset & w_pl_quiet;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = '0;
      case (r_state)
         // A confirmation still high from the last gating must drain first,
         // otherwise it would be mistaken for the new wake's confirmation.
         ST_GATED: begin
            if (w_wake_cond && !i_ltsm_is_waked_up)
               w_nxt_state = ST_WAKING;
         end
         ST_WAKING: begin
            if (i_ltsm_is_waked_up)
               w_nxt_state = i_lp_wake_req ? ST_ACK : ST_UNGATED;
         end
         ST_ACK: begin
            if (!i_ltsm_is_waked_up)
               w_nxt_state = ST_WAKING;
            else if (!i_lp_wake_req)
               w_nxt_state = ST_UNGATED;
         end
         ST_UNGATED: begin
            if (i_lp_wake_req) begin
               w_nxt_state = i_ltsm_is_waked_up ? ST_ACK : ST_WAKING;
            end else if (w_idle) begin
               if (r_idle_cnt == c_idle_last)
                  w_nxt_state = ST_GATED;
               else
                  w_nxt_cnt = r_idle_cnt + 1'b1;
            end
         end
         default: w_nxt_state = ST_GATED;
      endcase
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_GATED;
         r_idle_cnt    <= '0;
         o_clk_gate_en <= 1'b0;
         o_pl_wake_ack <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_idle_cnt    <= w_nxt_cnt;
         o_clk_gate_en <= (w_nxt_state != ST_GATED);
         o_pl_wake_ack <= (w_nxt_state == ST_ACK);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rdi_wake_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tb_rdi_wake_handshake
// Description : Directed bench for rdi_wake_handshake; the LTSM confirmation
//               is modelled as gate_en delayed by four clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rdi_wake_handshake;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] pl_state_sts = 4'b0000;
   logic [3:0] lp_state_req = 4'b0000;
   logic       ltsm_in_reset = 1'b1;
   logic       lp_wake_req = 1'b0;
   logic       ltsm_is_waked_up;
   logic       clk_gate_en;
   logic       pl_wake_ack;
   logic [3:0] dly = 4'b0000;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) dly <= {dly[2:0], clk_gate_en};
   assign ltsm_is_waked_up = dly[3];

   rdi_wake_handshake #(
      .IDLE_CYCLES (16),
      .CNT_W       (5)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_pl_state_sts     (pl_state_sts),
      .i_lp_state_req     (lp_state_req),
      .i_ltsm_in_reset    (ltsm_in_reset),
      .i_lp_wake_req      (lp_wake_req),
      .i_ltsm_is_waked_up (ltsm_is_waked_up),
      .o_clk_gate_en      (clk_gate_en),
      .o_pl_wake_ack      (pl_wake_ack)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset for two edges with everything quiet.
      step(2);
      check("rst_gate", clk_gate_en, 1'b0);
      check("rst_ack", pl_wake_ack, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         check("quiet_gate", clk_gate_en, 1'b0);
         check("quiet_ack", pl_wake_ack, 1'b0);
      end

      // Wake: gate opens on the first edge, ack five edges later.
      lp_wake_req = 1'b1;
      step(1);
      check("wake_gate", clk_gate_en, 1'b1);
      check("wake_ack_early", pl_wake_ack, 1'b0);
      step(4);
      check("wake_ack_wait", pl_wake_ack, 1'b0);
      step(1);
      check("wake_ack", pl_wake_ack, 1'b1);
      check("wake_ack_gate", clk_gate_en, 1'b1);
      step(10);
      check("ack_hold", pl_wake_ack, 1'b1);

      // Release with an active state request: ack drops, gate stays open.
      lp_wake_req = 1'b0;
      lp_state_req = 4'b0001;
      step(1);
      check("rel_ack", pl_wake_ack, 1'b0);
      check("rel_gate", clk_gate_en, 1'b1);
      step(30);
      check("busy_gate", clk_gate_en, 1'b1);

      // Idle in L1; wake at idle cycle 10 restarts the count.
      lp_state_req = 4'b0000;
      pl_state_sts = 4'b0100;
      step(9);
      check("idle9_gate", clk_gate_en, 1'b1);
      lp_wake_req = 1'b1;
      step(1);
      check("abort_ack", pl_wake_ack, 1'b1);
      check("abort_gate", clk_gate_en, 1'b1);
      lp_wake_req = 1'b0;
      step(1);
      check("abort_rel_ack", pl_wake_ack, 1'b0);
      // Wake arriving on the expiry edge keeps the clock ungated.
      step(15);
      check("idle15_gate", clk_gate_en, 1'b1);
      lp_wake_req = 1'b1;
      step(1);
      check("expiry_wake_gate", clk_gate_en, 1'b1);
      lp_wake_req = 1'b0;
      step(1);
      check("expiry_rel_ack", pl_wake_ack, 1'b0);
      step(15);
      check("idle_b15_gate", clk_gate_en, 1'b1);
      step(1);
      check("idle_b16_gate", clk_gate_en, 1'b0);
      step(10);
      check("gated_hold", clk_gate_en, 1'b0);

      // Short wake pulse: gate opens, no ack ever.
      lp_wake_req = 1'b1;
      step(1);
      check("pulse_gate", clk_gate_en, 1'b1);
      check("pulse_ack0", pl_wake_ack, 1'b0);
      step(1);
      lp_wake_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("pulse_noack", pl_wake_ack, 1'b0);
         check("pulse_gate_on", clk_gate_en, 1'b1);
      end
      step(15);
      check("pulse_idle15_gate", clk_gate_en, 1'b1);
      step(1);
      check("pulse_idle16_gate", clk_gate_en, 1'b0);

      // Immediate re-wake must wait out the stale confirmation.
      lp_wake_req = 1'b1;
      step(4);
      check("stale_gate", clk_gate_en, 1'b0);
      check("stale_ack", pl_wake_ack, 1'b0);
      step(1);
      check("rewake_gate", clk_gate_en, 1'b1);
      check("rewake_ack0", pl_wake_ack, 1'b0);
      step(4);
      check("rewake_ack_wait", pl_wake_ack, 1'b0);
      step(1);
      check("rewake_ack", pl_wake_ack, 1'b1);

      // Reset in ACK.
      rst = 1'b1;
      step(1);
      check("midrst_gate", clk_gate_en, 1'b0);
      check("midrst_ack", pl_wake_ack, 1'b0);
      rst = 1'b0;
      step(1);
      check("postrst_gate", clk_gate_en, 1'b0);
      check("postrst_ack", pl_wake_ack, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
